// File: rtl/dac_write_iq.sv
// Dual-DAC streaming writer: beat FIFO, prefill/sync/run sequencing, interleaved IQ or independent channels.
// Optional build macro DAC_WRITE_IQ_OFFSET_BINARY_EN: invert sample MSBs at the output register.
module dac_write_iq #(
  parameter int INT_DAC_DATA_WIDTH   = 14,
  parameter int INT_FIFO_DEPTH       = 16,
  parameter int INT_PREFILL          = 4,
  parameter bit BIT_INTERLEAVED_MODE = 1'b1
) (
  input  logic                            in_clk,
  input  logic                            in_rst_n,
  input  logic                            in_enable,
  input  logic [2*INT_DAC_DATA_WIDTH-1:0] in_data,
  input  logic                            in_valid,
  output logic                            out_ready,
  output logic [INT_DAC_DATA_WIDTH-1:0]   out_data_1,
  output logic [INT_DAC_DATA_WIDTH-1:0]   out_data_2,
  output logic                            out_sel,
  output logic                            out_iqrst,
  output logic                            out_running,
  output logic                            out_underflow
);

  localparam int W         = INT_DAC_DATA_WIDTH;
  localparam int INT_PTR_W = $clog2(INT_FIFO_DEPTH);
  localparam int INT_LVL_W = INT_PTR_W + 1;

  localparam logic [INT_LVL_W-1:0] LVL_FULL    = INT_LVL_W'(INT_FIFO_DEPTH);
  localparam logic [INT_LVL_W-1:0] LVL_PREFILL = INT_LVL_W'(INT_PREFILL);
  localparam logic [INT_LVL_W-1:0] LVL_ZERO    = {INT_LVL_W{1'b0}};
  localparam logic [INT_LVL_W-1:0] LVL_ONE     = INT_LVL_W'(1);
  localparam logic [INT_PTR_W-1:0] PTR_ONE     = INT_PTR_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [2*W-1:0]       r_mem [INT_FIFO_DEPTH];
  logic [INT_PTR_W-1:0] r_wr_ptr;
  logic [INT_PTR_W-1:0] r_rd_ptr;
  logic [INT_LVL_W-1:0] r_level;
  logic                 r_ready;
  logic [1:0]           r_state;
  logic                 r_phase;
  logic                 r_pair;
  logic [2*W-1:0]       r_beat;
  logic [W-1:0]         r_data_1;
  logic [W-1:0]         r_data_2;
  logic                 r_sel;
  logic                 r_iqrst;
  logic                 r_underflow;

  logic                 w_push;
  logic                 w_empty;
  logic                 w_phase_ok;
  logic                 w_pop_due;
  logic                 w_pop;
  logic [INT_LVL_W-1:0] w_level_nxt;
  logic [1:0]           w_state_nxt;

  function automatic logic [W-1:0] f_fmt(input logic [W-1:0] s);
`ifdef DAC_WRITE_IQ_OFFSET_BINARY_EN
    f_fmt = {~s[W-1], s[W-2:0]};
`else
    f_fmt = s;
`endif
  endfunction

  assign w_push     = in_valid && r_ready;
  assign w_empty    = (r_level == LVL_ZERO);
  // In IQ mode a new beat is only due at the start of a pair, and exit waits for that same boundary.
  assign w_phase_ok = BIT_INTERLEAVED_MODE ? ~r_phase : 1'b1;
  assign w_pop_due  = (r_state == ST_RUN) && in_enable && w_phase_ok;
  assign w_pop      = w_pop_due && !w_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_enable && (r_level >= LVL_PREFILL)) w_state_nxt = ST_SYNC;
        else                                       w_state_nxt = ST_IDLE;
      end
      ST_SYNC: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!in_enable && w_phase_ok) w_state_nxt = ST_IDLE;
        else                          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_wr_ptr <= {INT_PTR_W{1'b0}};
      r_rd_ptr <= {INT_PTR_W{1'b0}};
      r_level  <= LVL_ZERO;
      r_ready  <= 1'b1;
      r_state  <= ST_IDLE;
      r_beat   <= {(2*W){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_beat   <= r_mem[r_rd_ptr];
      end
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_FULL);
      r_state <= w_state_nxt;
    end
  end

  // Output stage trails the pop by one edge; on underflow r_beat is simply kept and re-driven.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_data_1    <= {W{1'b0}};
      r_data_2    <= {W{1'b0}};
      r_sel       <= 1'b0;
      r_iqrst     <= 1'b1;
      r_phase     <= 1'b0;
      r_pair      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_iqrst <= (r_state == ST_IDLE) && (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_data_1    <= {W{1'b0}};
          r_data_2    <= {W{1'b0}};
          r_sel       <= 1'b0;
          r_phase     <= 1'b0;
          r_pair      <= 1'b0;
          r_underflow <= 1'b0;
        end
        ST_SYNC: begin
          r_phase <= 1'b0;
          r_pair  <= 1'b0;
        end
        ST_RUN: begin
          if (w_pop_due) begin
            r_pair <= 1'b1;
            if (w_empty) r_underflow <= 1'b1;
          end
          if (BIT_INTERLEAVED_MODE) begin
            r_data_2 <= {W{1'b0}};
            r_phase  <= ~r_phase;
            if (r_phase) begin
              r_data_1 <= f_fmt(r_beat[W-1:0]);
              r_sel    <= 1'b1;
            end else if (r_pair) begin
              r_data_1 <= f_fmt(r_beat[2*W-1:W]);
              r_sel    <= 1'b0;
            end
          end else if (r_pair) begin
            r_data_1 <= f_fmt(r_beat[W-1:0]);
            r_data_2 <= f_fmt(r_beat[2*W-1:W]);
            r_sel    <= 1'b0;
          end
        end
        default: begin
          r_phase <= 1'b0;
          r_pair  <= 1'b0;
        end
      endcase
    end
  end

  assign out_ready     = r_ready;
  assign out_data_1    = r_data_1;
  assign out_data_2    = r_data_2;
  assign out_sel       = r_sel;
  assign out_iqrst     = r_iqrst;
  assign out_running   = (r_state == ST_RUN);
  assign out_underflow = r_underflow;

endmodule
